dcache_fill_buffer: RTL

- Parametrised multi-channel store/fill buffer in front of the dcache data array.
- Each channel is a true circular FIFO of {index, tag, data} entries with push and drain handshakes.
- Supports an associative search across all valid entries. Returns registered hit/data one cycle after the search, so loads can forward from in-flight lines.
- Round-robin drain arbiter feeds entries to the dcache write port.

---
 rtl/dcache_fill_buffer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/dcache_fill_buffer.sv
// dcache_fill_buffer: per-channel circular FIFOs of {index, tag, data} lines.
// Loads can search every in-flight entry and get a registered hit one cycle later.
// A round-robin arbiter offers channel heads to the dcache write port.
module dcache_fill_buffer #(
   parameter int NUM_CH    = 8,
   parameter int DEPTH     = 8,
   parameter int SET_BITS  = 3,
   parameter int TAG_BITS  = 10,
   parameter int DATA_BITS = 64
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      push_valid,
   input  logic [$clog2(NUM_CH)-1:0] push_ch,
   input  logic [SET_BITS-1:0]       push_index,
   input  logic [TAG_BITS-1:0]       push_tag,
   input  logic [DATA_BITS-1:0]      push_data,
   output logic                      push_ready,
   input  logic                      search_valid,
   input  logic [SET_BITS-1:0]       search_index,
   input  logic [TAG_BITS-1:0]       search_tag,
   output logic                      hit_valid,
   output logic [DATA_BITS-1:0]      hit_data,
   output logic                      drain_valid,
   output logic [$clog2(NUM_CH)-1:0] drain_ch,
   output logic [SET_BITS-1:0]       drain_index,
   output logic [TAG_BITS-1:0]       drain_tag,
   output logic [DATA_BITS-1:0]      drain_data,
   input  logic                      drain_ready,
   output logic [NUM_CH-1:0]         full,
   output logic [NUM_CH-1:0]         empty
);

   localparam int CH_W  = $clog2(NUM_CH);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [SET_BITS-1:0]  index;
      logic [TAG_BITS-1:0]  tag;
      logic [DATA_BITS-1:0] data;
   } entry_t;

   entry_t             mem_q  [NUM_CH][DEPTH];
   logic [PTR_W-1:0]   head_q [NUM_CH];
   logic [PTR_W-1:0]   head_d [NUM_CH];
   logic [PTR_W-1:0]   tail_q [NUM_CH];
   logic [PTR_W-1:0]   tail_d [NUM_CH];
   logic [CNT_W-1:0]   cnt_q  [NUM_CH];
   logic [CNT_W-1:0]   cnt_d  [NUM_CH];
   logic [CH_W-1:0]    rr_q, rr_d;
   logic               hit_valid_q, hit_valid_d;
   logic [DATA_BITS-1:0] hit_data_q, hit_data_d;

   logic               push_acc, pop;
   logic [NUM_CH-1:0]  push_sel, pop_sel;
   logic [CH_W-1:0]    arb_ch, cand;
   logic               arb_found;
   entry_t             head_ent;
   logic               srch_hit;
   logic [DATA_BITS-1:0] srch_data;
   logic [PTR_W-1:0]   slot;

   // Flags come straight from the registered occupancy counts.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         full[c]  = (cnt_q[c] == CNT_W'(DEPTH));
         empty[c] = (cnt_q[c] == '0);
      end
   end

   assign push_ready = !full[push_ch];
   assign push_acc   = push_valid && push_ready;

   // Round-robin pick: first non-empty channel at or above rr, wrapping.
   always_comb begin
      arb_ch    = rr_q;
      arb_found = 1'b0;
      cand      = rr_q;
      for (int k = 0; k < NUM_CH; k++) begin
         cand = rr_q + CH_W'(k);
         if (!arb_found && !empty[cand]) begin
            arb_found = 1'b1;
            arb_ch    = cand;
         end
      end
   end

   assign head_ent    = mem_q[arb_ch][head_q[arb_ch]];
   assign drain_valid = arb_found;
   assign drain_ch    = arb_ch;
   assign drain_index = head_ent.index;
   assign drain_tag   = head_ent.tag;
   assign drain_data  = head_ent.data;
   assign pop         = drain_valid && drain_ready;

   // Pointer/count next state; a same-channel push+pop leaves the count alone.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         push_sel[c] = push_acc && (push_ch == CH_W'(c));
         pop_sel[c]  = pop && (arb_ch == CH_W'(c));
         head_d[c]   = head_q[c];
         tail_d[c]   = tail_q[c];
         cnt_d[c]    = cnt_q[c];
         if (push_sel[c]) tail_d[c] = tail_q[c] + 1'b1;
         if (pop_sel[c])  head_d[c] = head_q[c] + 1'b1;
         if (push_sel[c] && !pop_sel[c]) cnt_d[c] = cnt_q[c] + 1'b1;
         if (!push_sel[c] && pop_sel[c]) cnt_d[c] = cnt_q[c] - 1'b1;
      end
      rr_d = pop ? arb_ch + CH_W'(1) : rr_q;
   end

   // Associative search: push bypass first, then lowest channel, youngest entry.
   always_comb begin
      srch_hit  = 1'b0;
      srch_data = '0;
      slot      = '0;
      if (push_acc && push_index == search_index && push_tag == search_tag) begin
         srch_hit  = 1'b1;
         srch_data = push_data;
      end
      for (int c = 0; c < NUM_CH; c++) begin
         for (int k = DEPTH - 1; k >= 0; k--) begin
            slot = head_q[c] + PTR_W'(k);
            if (!srch_hit && (CNT_W'(k) < cnt_q[c]) &&
                mem_q[c][slot].index == search_index &&
                mem_q[c][slot].tag == search_tag) begin
               srch_hit  = 1'b1;
               srch_data = mem_q[c][slot].data;
            end
         end
      end
      hit_valid_d = search_valid && srch_hit;
      hit_data_d  = hit_valid_d ? srch_data : hit_data_q;
   end

   // Control state with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int c = 0; c < NUM_CH; c++) begin
            head_q[c] <= '0;
            tail_q[c] <= '0;
            cnt_q[c]  <= '0;
         end
         rr_q        <= '0;
         hit_valid_q <= 1'b0;
         hit_data_q  <= '0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         cnt_q       <= cnt_d;
         rr_q        <= rr_d;
         hit_valid_q <= hit_valid_d;
         hit_data_q  <= hit_data_d;
      end
   end

   // Entry storage; contents need no reset because validity comes from head/count.
   always_ff @(posedge clock) begin
      if (reset && push_acc)
         mem_q[push_ch][tail_q[push_ch]] <= '{index: push_index, tag: push_tag, data: push_data};
   end

   assign hit_valid = hit_valid_q;
   assign hit_data  = hit_data_q;

endmodule
